game_sequencer: RTL and testbench

//  Per-frame game controller between USB keycode, VGA vsync and the moving objects (ball, block).

---
 rtl/game_pkg.sv | 23 ++
 rtl/vs_edge_sync.sv | 34 +++
 rtl/game_sequencer.sv | 139 +++++++++++++
 tb/tb_game_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer and its bench.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        HIT   = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_P     = 8'h13;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    // Objects sit at their start positions while waiting to start and while respawning.
    function automatic logic obj_reset_for(input state_t s);
        return (s == IDLE) || (s == HIT);
    endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Synchronises an async active-low strobe and emits a one-cycle tick on its falling edge.
// Latency: tick is high in the cycle that follows the 3rd Clk edge after async_in falls.
// Backpressure: none; one tick per falling edge.
// Ports: Clk, Reset (sync, active-high), async_in (async level), fall_tick (1-cycle pulse).
module vs_edge_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic fall_tick
);

    logic r_meta;
    logic r_sync;
    logic r_sync_q;
    logic r_tick;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_q <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_meta   <= async_in;
            r_sync   <= r_meta;
            r_sync_q <= r_sync;
            // Registered edge detect: a cleared history never looks like a falling edge.
            r_tick   <= r_sync_q & ~r_sync;
        end
    end

    assign fall_tick = r_tick;

endmodule

// File: rtl/game_sequencer.sv
// Per-frame game controller: key edge detect, game FSM, object update/reset, lives and score.
// Latency: update_en pulses in the cycle after the 3rd Clk edge following a vs fall; state changes one Clk later.
// Backpressure: none; at most one update_en pulse per vs period.
// Ports: Clk, Reset (sync active-high), vs (async, active low), keycode[7:0], collide (level)
//        -> game_state, update_en (pulse), obj_reset (level), lives[2:0], score[SCORE_W-1:0] (saturating).
// Optional feature: define GAME_SEQ_PAUSE_EN to make PAUSE reachable from PLAY via PAUSE_KEY.
module game_sequencer
    import game_pkg::*;
#(
    parameter logic [7:0] START_KEY      = KEY_SPACE,
    parameter logic [7:0] PAUSE_KEY      = KEY_P,
    parameter int         LIVES_INIT     = 3,
    parameter int         RESPAWN_FRAMES = 60,
    parameter int         SCORE_W        = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               vs,
    input  logic [7:0]         keycode,
    input  logic               collide,
    output state_t             game_state,
    output logic               update_en,
    output logic               obj_reset,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score
);

    state_t             r_state;
    logic [2:0]         r_lives;
    logic [SCORE_W-1:0] r_score;
    logic [7:0]         r_timer;
    logic [7:0]         r_key_q;
    logic               r_obj_reset;

    logic               w_tick;
    logic               w_start_press;
    logic               w_pause_press;
    logic               w_update;
    state_t             w_next_state;
    logic [2:0]         w_next_lives;
    logic [SCORE_W-1:0] w_next_score;
    logic [7:0]         w_next_timer;

    vs_edge_sync u_vs_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .async_in  (vs),
        .fall_tick (w_tick)
    );

    // A held key fires once: only the cycle the keycode first matches.
    assign w_start_press = (keycode == START_KEY) && (r_key_q != START_KEY);
    assign w_pause_press = (keycode == PAUSE_KEY) && (r_key_q != PAUSE_KEY);

    always_comb begin
        w_next_state = r_state;
        w_next_lives = r_lives;
        w_next_score = r_score;
        w_next_timer = r_timer;
        w_update     = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                if (w_start_press) begin
                    w_next_state = PLAY;
                    w_next_lives = 3'(LIVES_INIT);
                    w_next_score = '0;
                end
            end
            PLAY: begin
                if (w_tick) begin
                    w_update = 1'b1;
                    if (r_score != {SCORE_W{1'b1}}) begin
                        w_next_score = r_score + 1'b1;
                    end
                end
                // Collision on a tick wins over a coincident pause press.
                if (w_tick && collide) begin
                    if (r_lives <= 3'd1) begin
                        w_next_lives = 3'd0;
                        w_next_state = OVER;
                    end else begin
                        w_next_lives = r_lives - 3'd1;
                        w_next_timer = 8'(RESPAWN_FRAMES);
                        w_next_state = HIT;
                    end
                end
`ifdef GAME_SEQ_PAUSE_EN
                else if (w_pause_press) begin
                    w_next_state = PAUSE;
                end
`endif
            end
            HIT: begin
                if (w_tick) begin
                    if (r_timer <= 8'd1) begin
                        w_next_timer = 8'd0;
                        w_next_state = PLAY;
                    end else begin
                        w_next_timer = r_timer - 8'd1;
                    end
                end
            end
            PAUSE: begin
                // Only reachable when the pause feature is built in.
                if (w_pause_press) begin
                    w_next_state = PLAY;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_lives     <= 3'd0;
            r_score     <= '0;
            r_timer     <= 8'd0;
            r_key_q     <= KEY_NONE;
            r_obj_reset <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_lives     <= w_next_lives;
            r_score     <= w_next_score;
            r_timer     <= w_next_timer;
            r_key_q     <= keycode;
            r_obj_reset <= obj_reset_for(w_next_state);
        end
    end

    assign game_state = r_state;
    assign update_en  = w_update;
    assign obj_reset  = r_obj_reset;
    assign lives      = r_lives;
    assign score      = r_score;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised bench for game_sequencer with a frame-level reference model and pulse scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_game_sequencer;
    import game_pkg::*;

    localparam int SW    = 6;
    localparam int SMAX  = (1 << SW) - 1;
    localparam int RESP  = 60;
    localparam int LIVES = 3;
`ifdef GAME_SEQ_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic          Clk     = 1'b0;
    logic          Reset   = 1'b1;
    logic          vs      = 1'b1;
    logic [7:0]    keycode = 8'h00;
    logic          collide = 1'b0;
    state_t        game_state;
    logic          update_en;
    logic          obj_reset;
    logic [2:0]    lives;
    logic [SW-1:0] score;

    game_sequencer #(.SCORE_W(SW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .vs         (vs),
        .keycode    (keycode),
        .collide    (collide),
        .game_state (game_state),
        .update_en  (update_en),
        .obj_reset  (obj_reset),
        .lives      (lives),
        .score      (score)
    );

    always #10 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int at;
        int sc;
    } exp_t;
    exp_t expq[$];

    // Reference model, advanced one frame / one key press at a time.
    state_t ms;
    int     ml;
    int     msc;
    int     mt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every update_en pulse must match the oldest expected one.
    always @(negedge Clk) begin
        if (!Reset && update_en) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got update_en=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_score", int'(score), e.sc);
                chk("pulse_state", int'(game_state), int'(PLAY));
            end
        end
    end

    task automatic check_model(input string name);
        chk({name, "_state"}, int'(game_state), int'(ms));
        chk({name, "_lives"}, int'(lives), ml);
        chk({name, "_score"}, int'(score), msc);
        chk({name, "_objrst"}, int'(obj_reset), int'((ms == IDLE) || (ms == HIT)));
    endtask

    task automatic model_reset();
        ms  = IDLE;
        ml  = 0;
        msc = 0;
        mt  = 0;
    endtask

    task automatic model_key(input logic [7:0] k);
        if (k == KEY_SPACE && (ms == IDLE || ms == OVER)) begin
            ms  = PLAY;
            ml  = LIVES;
            msc = 0;
        end else if (k == KEY_P && PAUSE_ON) begin
            if (ms == PLAY)       ms = PAUSE;
            else if (ms == PAUSE) ms = PLAY;
        end
    endtask

    task automatic press(input logic [7:0] k);
        @(posedge Clk); #1 keycode = k;
        @(posedge Clk); #1 keycode = KEY_NONE;
        model_key(k);
        @(posedge Clk); #1;
    endtask

    // One vs period; optionally a pause press landing exactly on the frame tick.
    task automatic frame(input bit col, input bit ptick);
        state_t pre;
        bool_hit: begin end
        @(posedge Clk); #1;
        vs      = 1'b0;
        collide = col;
        pre = ms;
        if (pre == PLAY) begin
            expq.push_back('{at: cyc + 3, sc: msc});
            if (msc < SMAX) msc++;
            if (col) begin
                if (ml == 1) begin
                    ml = 0;
                    ms = OVER;
                end else begin
                    ml--;
                    mt = RESP;
                    ms = HIT;
                end
            end else if (ptick && PAUSE_ON) begin
                ms = PAUSE;
            end
        end else if (pre == HIT) begin
            mt--;
            if (mt == 0) ms = PLAY;
        end else if (pre == PAUSE && ptick && PAUSE_ON) begin
            ms = PLAY;
        end
        repeat (3) @(posedge Clk);
        #1 if (ptick) keycode = KEY_P;
        @(posedge Clk);
        #1;
        if (ptick) keycode = KEY_NONE;
        collide = 1'b0;
        repeat (3) @(posedge Clk);
        #1 vs = 1'b1;
        repeat (4) @(posedge Clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        // 1: reset state, then idle frames with no keys
        repeat (3) @(posedge Clk);
        #1;
        check_model("reset");
        chk("reset_upd", int'(update_en), 0);
        Reset = 1'b0;
        frames(5);
        check_model("idle5");

        // 2: start key held for 10 frames fires once
        @(posedge Clk); #1 keycode = KEY_SPACE;
        model_key(KEY_SPACE);
        frames(10);
        #1 keycode = KEY_NONE;
        check_model("held_start");
        chk("held_start_score10", int'(score), 10);

        // 3: collision with lives=3 -> HIT for exactly RESP ticks
        frame(1'b1, 1'b0);
        check_model("hit_entry");
        frames(RESP - 1);
        chk("hit_still", int'(game_state), int'(HIT));
        frame(1'b0, 1'b0);
        check_model("hit_exit");

        // 4: lose remaining lives -> OVER, frozen, then restart
        frame(1'b1, 1'b0);
        frames(RESP);
        frame(1'b1, 1'b0);
        check_model("over_entry");
        chk("over_lives0", int'(lives), 0);
        frames(3);
        check_model("over_frozen");
        press(KEY_SPACE);
        check_model("restart");

        // 5: pause press coincident with a tick, paused frames, resume
        frames(2);
        frame(1'b0, 1'b1);
        check_model("pause_tick");
        frames(5);
        check_model("paused");
        press(KEY_P);
        check_model("resume");
        press(KEY_SPACE);
        check_model("start_ignored");

        // 6: reset mid-HIT
        frame(1'b1, 1'b0);
        frames(4);
        @(posedge Clk); #1 Reset = 1'b1;
        @(posedge Clk); #1;
        model_reset();
        check_model("reset_mid_hit");
        Reset = 1'b0;
        press(KEY_SPACE);
        frame(1'b1, 1'b0);
        frames(RESP - 1);
        chk("timer_reload_hit", int'(game_state), int'(HIT));
        frame(1'b0, 1'b0);
        check_model("timer_reload_exit");

        // score saturation
        frames(SMAX + 5);
        check_model("saturate");
        chk("saturate_max", int'(score), SMAX);

        // randomised mix of frames, collisions and key presses
        for (int i = 0; i < 250; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8)       press(KEY_SPACE);
            else if (r < 16) press(KEY_P);
            else if (r < 22) frame(1'b0, 1'b1);
            else             frame(r < 30, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge Clk);
            #1 check_model("rand");
        end

        repeat (20) @(posedge Clk);
        chk("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
